// File: rtl/mdu_seq.sv
// Execute-stage multiply/divide sequencer: launches MULT/DIV operations, holds the
// unit busy for a fixed latency, owns HI/LO and raises the D-stage MD stall request.
module mdu_seq #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        d_is_md,
  output logic        start,
  output logic        busy,
  output logic        stall_d,
  output logic [31:0] md_rd,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic             wr_q, wr_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic               is_arith;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] sdvd;
  logic signed [31:0] sdvs;
  logic [31:0]        quo_s;
  logic [31:0]        rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;
  logic               div_zero;
  logic               div_ovf;

  assign is_arith = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                    (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign busy     = (state_q == RUN);
  assign start    = is_arith & ~busy;
  assign stall_d  = d_is_md & (start | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    md_rd = '0;
    if (md_op == OP_MFHI) md_rd = hi_q;
    else if (md_op == OP_MFLO) md_rd = lo_q;
  end

  // Sign-extending both operands to 64 bits makes the low 64 bits of the product exact.
  assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  assign prod_u = {32'b0, op_a} * {32'b0, op_b};

  assign sdvd     = op_a;
  assign sdvs     = op_b;
  assign div_zero = (op_b == '0);
  assign div_ovf  = (op_a == 32'h8000_0000) && (op_b == '1);

  // Divisor is forced to 1 when unused so the dividers never see zero;
  // the most-negative / -1 overflow is resolved explicitly.
  always_comb begin
    quo_s = '0;
    rem_s = '0;
    quo_u = '0;
    rem_u = '0;
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
      rem_s = '0;
    end else begin
      quo_s = sdvd / (div_zero ? 32'sd1 : sdvs);
      rem_s = sdvd % (div_zero ? 32'sd1 : sdvs);
    end
    quo_u = op_a / (div_zero ? 32'd1 : op_b);
    rem_u = op_a % (div_zero ? 32'd1 : op_b);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          wr_d    = 1'b1;
          case (md_op)
            OP_MULT: begin
              cnt_d    = CNT_W'(MULT_CYCLES);
              res_hi_d = prod_s[63:32];
              res_lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
              cnt_d    = CNT_W'(MULT_CYCLES);
              res_hi_d = prod_u[63:32];
              res_lo_d = prod_u[31:0];
            end
            OP_DIV: begin
              cnt_d    = CNT_W'(DIV_CYCLES);
              res_hi_d = rem_s;
              res_lo_d = quo_s;
              wr_d     = ~div_zero;
            end
            default: begin
              cnt_d    = CNT_W'(DIV_CYCLES);
              res_hi_d = rem_u;
              res_lo_d = quo_u;
              wr_d     = ~div_zero;
            end
          endcase
        end else if (md_op == OP_MTHI) begin
          hi_d = op_a;
        end else if (md_op == OP_MTLO) begin
          lo_d = op_a;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wr_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: the driver pushes expected commits/reads computed
// from a 64-bit arithmetic reference; an independent monitor pops and compares.
module tb_mdu_seq;

  localparam int unsigned MULT_C = 5;
  localparam int unsigned DIV_C  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        d_is_md;
  logic        start;
  logic        busy;
  logic        stall_d;
  logic [31:0] md_rd;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_seq #(
    .MULT_CYCLES(MULT_C),
    .DIV_CYCLES (DIV_C),
    .CNT_W      (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .op_a   (op_a),
    .op_b   (op_b),
    .d_is_md(d_is_md),
    .start  (start),
    .busy   (busy),
    .stall_d(stall_d),
    .md_rd  (md_rd),
    .hi     (hi),
    .lo     (lo)
  );

  typedef struct {
    bit          is_read;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference arithmetic on 64-bit integers: no overflow cases exist at this width.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output bit wr);
    longint          sa, sb_v, q, r;
    longint unsigned ua, ub, p, pr;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    wr   = 1'b1;
    h    = '0;
    l    = '0;
    case (op)
      4'd1: begin q = sa * sb_v; h = q[63:32]; l = q[31:0]; end
      4'd2: begin p = ua * ub;   h = p[63:32]; l = p[31:0]; end
      4'd3: begin
        if (b == 32'd0) wr = 1'b0;
        else begin q = sa / sb_v; r = sa % sb_v; h = r[31:0]; l = q[31:0]; end
      end
      default: begin
        if (b == 32'd0) wr = 1'b0;
        else begin p = ua / ub; pr = ua % ub; h = pr[31:0]; l = p[31:0]; end
      end
    endcase
  endfunction

  function automatic logic pick(input int dmode);
    if (dmode == 0) return 1'b0;
    if (dmode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_read(input logic [3:0] op);
    exp_t e;
    e.is_read = 1'b1;
    e.hi      = '0;
    e.lo      = '0;
    e.rd      = (op == 4'd7) ? m_hi : m_lo;
    e.cycles  = 0;
    sb.push_back(e);
  endtask

  task automatic arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int dmode, input logic [3:0] follow);
    logic [31:0] h, l, old_h, old_l;
    bit          wr;
    int          n;
    exp_t        e;
    int          v;
    ref_op(op, a, b, h, l, wr);
    n     = (op <= 4'd2) ? int'(MULT_C) : int'(DIV_C);
    old_h = m_hi;
    old_l = m_lo;
    @(posedge clk); #1;
    md_op   = op;
    op_a    = a;
    op_b    = b;
    d_is_md = pick(dmode);
    if (wr) begin m_hi = h; m_lo = l; end
    e.is_read = 1'b0;
    e.hi      = m_hi;
    e.lo      = m_lo;
    e.rd      = '0;
    e.cycles  = n;
    sb.push_back(e);
    @(negedge clk);
    chk("start_launch", {31'b0, start}, 32'd1);
    chk("stall_launch", {31'b0, stall_d}, {31'b0, d_is_md});
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      v       = int'($urandom_range(0, 12));
      md_op   = (v <= 6) ? 4'(v) : 4'(v + 2);
      op_a    = $urandom;
      op_b    = $urandom;
      d_is_md = pick(dmode);
      @(negedge clk);
      chk("busy_run", {31'b0, busy}, 32'd1);
      chk("start_masked", {31'b0, start}, 32'd0);
      chk("stall_run", {31'b0, stall_d}, {31'b0, d_is_md});
      chk("hold_hi", hi, old_h);
      chk("hold_lo", lo, old_l);
    end
    @(posedge clk); #1;
    md_op   = follow;
    d_is_md = pick(dmode);
    if (follow == 4'd7 || follow == 4'd8) push_read(follow);
    @(negedge clk);
    chk("busy_done", {31'b0, busy}, 32'd0);
    chk("stall_done", {31'b0, stall_d}, 32'd0);
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] v);
    @(posedge clk); #1;
    md_op   = op;
    op_a    = v;
    d_is_md = 1'b1;
    if (op == 4'd5) m_hi = v;
    else m_lo = v;
    @(negedge clk);
    chk("stall_mt", {31'b0, stall_d}, 32'd0);
  endtask

  task automatic do_read(input logic [3:0] op);
    @(posedge clk); #1;
    md_op   = op;
    d_is_md = 1'b1;
    push_read(op);
    @(negedge clk);
    chk("stall_rd", {31'b0, stall_d}, 32'd0);
  endtask

  task automatic chk_const(input string name, input logic [31:0] h, input logic [31:0] l);
    @(posedge clk); #1;
    md_op = 4'd0;
    @(negedge clk);
    chk({name, "_hi"}, hi, h);
    chk({name, "_lo"}, lo, l);
  endtask

  // Monitor: every busy fall is a commit, every idle MFHI/MFLO is a read.
  initial begin
    int   bcnt;
    bit   bprev;
    exp_t e;
    bcnt  = 0;
    bprev = 1'b0;
    forever begin
      @(negedge clk);
      if (bprev && busy === 1'b0) begin
        chk("sb_commit_avail", {31'b0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_order_commit", {31'b0, e.is_read}, 32'd0);
          chk("commit_hi", hi, e.hi);
          chk("commit_lo", lo, e.lo);
          chk("busy_len", bcnt, e.cycles);
        end
        bcnt = 0;
      end
      if (busy === 1'b1) bcnt++;
      if (busy === 1'b0 && reset === 1'b0 && (md_op == 4'd7 || md_op == 4'd8)) begin
        chk("sb_read_avail", {31'b0, (sb.size() > 0)}, 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("sb_order_read", {31'b0, e.is_read}, 32'd1);
          chk("md_rd", md_rd, e.rd);
        end
      end
      bprev = (busy === 1'b1);
    end
  end

  initial begin
    exp_t        e;
    int          r;
    logic [3:0]  op, fol;
    logic [31:0] a, b;
    reset   = 1'b1;
    md_op   = 4'd0;
    op_a    = '0;
    op_b    = '0;
    d_is_md = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'b0, stall_d}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    arith(4'd1, 32'd3, 32'hFFFF_FFFE, 1, 4'd0);
    chk_const("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    arith(4'd2, 32'hFFFF_FFFF, 32'd2, 0, 4'd8);
    chk_const("multu", 32'd1, 32'hFFFF_FFFE);
    arith(4'd3, 32'hFFFF_FFF9, 32'd2, 2, 4'd7);
    chk_const("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    arith(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 2, 4'd0);
    chk_const("div_ovf", 32'd0, 32'h8000_0000);
    do_mt(4'd5, 32'h11);
    do_mt(4'd6, 32'h22);
    arith(4'd4, 32'd7, 32'd0, 2, 4'd8);
    chk_const("divu_zero", 32'h11, 32'h22);
    do_mt(4'd5, 32'hDEAD_BEEF);
    do_read(4'd7);

    // Reset during the 4th busy cycle of a DIV: the staged result must never land.
    @(posedge clk); #1;
    md_op = 4'd3;
    op_a  = 32'd100;
    op_b  = 32'd7;
    m_hi  = '0;
    m_lo  = '0;
    e.is_read = 1'b0;
    e.hi      = '0;
    e.lo      = '0;
    e.rd      = '0;
    e.cycles  = 4;
    sb.push_back(e);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      md_op = 4'd0;
      if (i == 4) reset = 1'b1;
      @(negedge clk);
      chk("abort_busy_run", {31'b0, busy}, 32'd1);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (12) @(negedge clk);
    chk("abort_nocommit_hi", hi, 32'd0);
    chk("abort_nocommit_lo", lo, 32'd0);
    chk("abort_nocommit_busy", {31'b0, busy}, 32'd0);

    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 5));
      if (r <= 3) begin
        op = 4'($urandom_range(1, 4));
        a  = $urandom;
        b  = $urandom;
        case ($urandom_range(0, 7))
          0: b = '0;
          1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          2: begin a = 32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
          3: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
          default: ;
        endcase
        fol = 4'($urandom_range(0, 2));
        fol = (fol == 4'd0) ? 4'd0 : fol + 4'd6;
        arith(op, a, b, 2, fol);
      end else if (r == 4) begin
        do_mt(4'($urandom_range(5, 6)), $urandom);
      end else begin
        do_read(4'($urandom_range(7, 8)));
      end
    end

    @(posedge clk); #1;
    md_op   = 4'd0;
    d_is_md = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
